// File: rtl/nios_debug_scan_master_if.sv
// Command/response handshake bundle between a scan requester and the
// virtual-JTAG scan master.
interface nios_debug_scan_master_if #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_ir_en;
  logic [IR_WIDTH-1:0] cmd_ir;
  logic [DR_WIDTH-1:0] cmd_data;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DR_WIDTH-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_ir_en, cmd_ir, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_ir_en, cmd_ir, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/nios_debug_scan_master.sv
// Host-side virtual-JTAG initiator: per command, one optional IR update and one
// DR scan towards the Nios II debug slave, returning the captured tdo bits.
module nios_debug_scan_master #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2,
  parameter int TCK_DIV  = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  nios_debug_scan_master_if.slave bus,
  output logic                tck,
  output logic                tdi,
  input  logic                tdo,
  output logic [IR_WIDTH-1:0] ir_in,
  output logic                vs_uir,
  output logic                vs_cdr,
  output logic                vs_sdr,
  output logic                vs_udr,
  output logic                jtag_state_rti
);

  typedef enum logic [2:0] {IDLE, UIR, CDR, SDR, UDR, RTI, DONE} state_t;

  localparam int DIV_W = $clog2(2 * TCK_DIV);
  localparam int BIT_W = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
  localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(TCK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * TCK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DR_WIDTH - 1);

  state_t              state;
  logic [DIV_W-1:0]    div_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [DR_WIDTH-1:0] data_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      div_cnt        <= '0;
      bit_cnt        <= '0;
      data_q         <= '0;
      tck            <= 1'b0;
      tdi            <= 1'b0;
      ir_in          <= '0;
      vs_uir         <= 1'b0;
      vs_cdr         <= 1'b0;
      vs_sdr         <= 1'b0;
      vs_udr         <= 1'b0;
      jtag_state_rti <= 1'b0;
      bus.cmd_ready  <= 1'b0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.cmd_ready <= 1'b1;
          tck           <= 1'b0;
          div_cnt       <= '0;
          bit_cnt       <= '0;
          // Phase outputs of the first period are driven on the accept edge
          if (bus.cmd_valid && bus.cmd_ready) begin
            bus.cmd_ready <= 1'b0;
            data_q        <= bus.cmd_data;
            if (bus.cmd_ir_en) begin
              state  <= UIR;
              vs_uir <= 1'b1;
              ir_in  <= bus.cmd_ir;
            end else begin
              state  <= CDR;
              vs_cdr <= 1'b1;
            end
          end
        end

        DONE: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.cmd_ready <= 1'b1;
            state         <= IDLE;
          end
        end

        default: begin
          div_cnt <= div_cnt + 1'b1;
          if (div_cnt == DIV_RISE) begin
            tck <= 1'b1;
            if (state == SDR) bus.rsp_data[bit_cnt] <= tdo;
          end
          // Period boundary: tck falls and the next phase's outputs launch
          if (div_cnt == DIV_LAST) begin
            tck     <= 1'b0;
            div_cnt <= '0;
            case (state)
              UIR: begin
                vs_uir <= 1'b0;
                vs_cdr <= 1'b1;
                state  <= CDR;
              end
              CDR: begin
                vs_cdr  <= 1'b0;
                vs_sdr  <= 1'b1;
                tdi     <= data_q[0];
                data_q  <= data_q >> 1;
                bit_cnt <= '0;
                state   <= SDR;
              end
              SDR: begin
                if (bit_cnt == BIT_LAST) begin
                  vs_sdr <= 1'b0;
                  vs_udr <= 1'b1;
                  tdi    <= 1'b0;
                  state  <= UDR;
                end else begin
                  bit_cnt <= bit_cnt + 1'b1;
                  tdi     <= data_q[0];
                  data_q  <= data_q >> 1;
                end
              end
              UDR: begin
                vs_udr         <= 1'b0;
                jtag_state_rti <= 1'b1;
                state          <= RTI;
              end
              RTI: begin
                jtag_state_rti <= 1'b0;
                bus.rsp_valid  <= 1'b1;
                state          <= DONE;
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule
